// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-port RV32 register file with x0, write bypass and an optional pending scoreboard.
// Define REGFILE_SCOREBOARD_EN to build the pending bits and rd_busy; otherwise rd_busy is tied low.
module register_bank_mp #(
    parameter int WORD_SIZE = 32,
    parameter int BANK_SIZE = 32,
    parameter int ADDR_W    = $clog2(BANK_SIZE),
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*WORD_SIZE-1:0] rd_data,
    input  logic                        we0,
    input  logic [ADDR_W-1:0]           wa0,
    input  logic [WORD_SIZE-1:0]        wd0,
    input  logic                        we1,
    input  logic [ADDR_W-1:0]           wa1,
    input  logic [WORD_SIZE-1:0]        wd1,
    input  logic                        iss_valid,
    input  logic [ADDR_W-1:0]           iss_rd,
    input  logic                        flush,
    output logic [NUM_RD-1:0]           rd_busy
);
    logic [WORD_SIZE-1:0] regs [BANK_SIZE];
    logic wok0, wok1;
    assign wok0 = we0 && !(ZERO_REG != 0 && wa0 == '0);
    assign wok1 = we1 && !(ZERO_REG != 0 && wa1 == '0);
    // Port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BANK_SIZE; i++) regs[i] <= '0;
        end else begin
            if (wok0) regs[wa0] <= wd0;
            if (wok1) regs[wa1] <= wd1;
        end
    end
`ifdef REGFILE_SCOREBOARD_EN
    logic [BANK_SIZE-1:0] pending, pending_nxt;
    // Set after clear so a newly issued producer supersedes a retiring one; flush overrides all.
    always_comb begin
        pending_nxt = pending;
        if (we0) pending_nxt[wa0] = 1'b0;
        if (we1) pending_nxt[wa1] = 1'b0;
        if (iss_valid && !(ZERO_REG != 0 && iss_rd == '0)) pending_nxt[iss_rd] = 1'b1;
        if (flush) pending_nxt = '0;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pending <= '0;
        else pending <= pending_nxt;
    end
`else
    logic unused_sb;
    assign unused_sb = ^{iss_valid, iss_rd, flush};
`endif
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic z, h0, h1;
        assign a  = rd_addr[k*ADDR_W +: ADDR_W];
        assign z  = ZERO_REG != 0 && a == '0;
        assign h0 = we0 && wa0 == a;
        assign h1 = we1 && wa1 == a;
        assign rd_data[k*WORD_SIZE +: WORD_SIZE] = (!rstn || z) ? '0 : h1 ? wd1 : h0 ? wd0 : regs[a];
`ifdef REGFILE_SCOREBOARD_EN
        assign rd_busy[k] = pending[a] && !h0 && !h1 && !z;
`else
        assign rd_busy[k] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_register_bank_mp.sv
// tb_register_bank_mp: directed and random checks of register_bank_mp against an array-based model.
module tb_register_bank_mp;
`ifdef REGFILE_SCOREBOARD_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif
    logic        clk = 0, rstn = 1;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        we0, we1, iss_valid, flush;
    logic [4:0]  wa0, wa1, iss_rd;
    logic [31:0] wd0, wd1;
    logic [1:0]  rd_busy;
    int errors = 0, checks = 0;
    logic [31:0] mdl [32];
    bit          pend [32];

    register_bank_mp dut (
        .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush), .rd_busy(rd_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return mdl[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        bit written = (we0 && wa0 == a) || (we1 && wa1 == a);
        return EN && a != 0 && pend[a] && !written;
    endfunction

    task automatic idle();
        we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
        iss_valid = 0; iss_rd = 0; flush = 0; rd_addr = 0;
    endtask

    task automatic tick();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rd_data%0d", k), rd_data[k*32 +: 32], exp_rd(rd_addr[k*5 +: 5]));
            check($sformatf("rd_busy%0d", k), 32'(rd_busy[k]), 32'(exp_busy(rd_addr[k*5 +: 5])));
        end
        @(posedge clk);
        if (we0 && wa0 != 0) mdl[wa0] = wd0;
        if (we1 && wa1 != 0) mdl[wa1] = wd1;
        if (flush) begin
            foreach (pend[i]) pend[i] = 0;
        end else begin
            if (we0) pend[wa0] = 0;
            if (we1) pend[wa1] = 0;
            if (iss_valid && iss_rd != 0) pend[iss_rd] = 1;
        end
        #1;
    endtask

    initial begin
        idle();
        we0 = 1; wa0 = 5; wd0 = 32'hCAFE_F00D; rd_addr = {5'd5, 5'd5};
        #2 rstn = 0;
        #1;
        check("reset_rd0", rd_data[31:0], 0);
        check("reset_rd1", rd_data[63:32], 0);
        check("reset_busy", 32'(rd_busy), 0);
        foreach (mdl[i]) begin mdl[i] = 0; pend[i] = 0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1;
        idle(); rd_addr = {5'd5, 5'd5};
        #1 check("x5_after_reset", rd_data[31:0], 0);
        tick();

        idle(); we0 = 1; wa0 = 3; wd0 = 32'hDEADBEEF; tick();
        idle(); rd_addr[4:0] = 3;
        #1 check("x3_read", rd_data[31:0], 32'hDEADBEEF);
        tick();

        idle(); we0 = 1; wa0 = 0; wd0 = 32'h1234;
        #1 check("x0_same_cycle", rd_data[31:0], 0);
        tick();
        idle();
        #1 check("x0_next_cycle", rd_data[31:0], 0);
        tick();

        idle(); we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; rd_addr[4:0] = 7;
        #1 check("bypass_port1_wins", rd_data[31:0], 32'h22);
        tick();
        idle(); rd_addr[4:0] = 7;
        #1 check("x7_stored", rd_data[31:0], 32'h22);
        tick();

        idle(); iss_valid = 1; iss_rd = 9; tick();
        idle(); rd_addr[9:5] = 9;
        #1 check("x9_busy", 32'(rd_busy[1]), 32'(EN));
        tick();
        idle(); we1 = 1; wa1 = 9; wd1 = 32'h55; rd_addr[9:5] = 9;
        #1 check("x9_release", 32'(rd_busy[1]), 0);
        check("x9_bypass", rd_data[63:32], 32'h55);
        tick();
        idle(); rd_addr[9:5] = 9;
        #1 check("x9_cleared", 32'(rd_busy[1]), 0);
        tick();

        idle(); iss_valid = 1; iss_rd = 4; we0 = 1; wa0 = 4; wd0 = 32'h44; tick();
        idle(); rd_addr[4:0] = 4;
        #1 check("x4_set_wins", 32'(rd_busy[0]), 32'(EN));
        check("x4_data", rd_data[31:0], 32'h44);
        tick();
        idle(); flush = 1; iss_valid = 1; iss_rd = 6; tick();
        idle();
        for (int r = 0; r < 32; r++) begin
            rd_addr = {5'(r), 5'(r)};
            #1 check($sformatf("flush_busy_x%0d", r), 32'(rd_busy), 0);
        end
        tick();

        for (int n = 0; n < 400; n++) begin
            idle();
            we0 = 1'($urandom); wa0 = 5'($urandom_range(0, 15)); wd0 = $urandom;
            we1 = 1'($urandom); wa1 = 5'($urandom_range(0, 15)); wd1 = $urandom;
            iss_valid = 1'($urandom); iss_rd = 5'($urandom_range(0, 15));
            flush = ($urandom_range(0, 7) == 0);
            rd_addr = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
